// File: rtl/cc_cond_unit.sv
// Execute-stage condition-code unit: holds the Y86-64 CC register, evaluates the
// jXX/cmovXX condition from it, and registers the result into the E->M boundary.
module cc_cond_unit #(
  parameter logic [3:0] ICODE_CMOV = 4'h2,
  parameter logic [3:0] ICODE_OPQ  = 4'h6,
  parameter logic [3:0] ICODE_JXX  = 4'h7,
  parameter logic [2:0] CC_RESET   = 3'b001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       e_valid,
  input  logic [3:0] e_icode,
  input  logic [3:0] e_ifun,
  input  logic [2:0] alu_cf,
  input  logic       cc_hold,
  input  logic       m_stall,
  input  logic       m_bubble,
  output logic [2:0] cc,
  output logic       e_cnd,
  output logic       m_cnd,
  output logic       m_valid
);

  logic [2:0] cc_r;
  logic       m_cnd_r;
  logic       m_valid_r;
  logic       set_cc_s;
  logic       is_cond_s;
  logic       e_cnd_s;

  // Flags are {OF,SF,ZF}; x = SF^OF is the signed "less than" result.
  function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] flags);
    logic zf;
    logic x;
    logic res;
    zf = flags[0];
    x  = flags[1] ^ flags[2];
    case (ifun)
      4'h0:    res = 1'b1;
      4'h1:    res = x | zf;
      4'h2:    res = x;
      4'h3:    res = zf;
      4'h4:    res = ~zf;
      4'h5:    res = ~x;
      4'h6:    res = ~x & ~zf;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  assign set_cc_s  = e_valid & (e_icode == ICODE_OPQ) & ~cc_hold;
  assign is_cond_s = e_valid & ((e_icode == ICODE_JXX) | (e_icode == ICODE_CMOV));

  // Condition evaluated from the registered CC only; no bypass of a same-cycle write.
  always_comb begin
    e_cnd_s = 1'b0;
    if (is_cond_s) begin
      e_cnd_s = cond_eval(e_ifun, cc_r);
    end else begin
      e_cnd_s = 1'b0;
    end
  end

  // Architectural CC register, written only by a committed OPq.
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_r <= CC_RESET;
    end else if (set_cc_s) begin
      cc_r <= alu_cf;
    end else begin
      cc_r <= cc_r;
    end
  end

  // E->M boundary: stall outranks bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_cnd_r   <= 1'b0;
      m_valid_r <= 1'b0;
    end else if (m_stall) begin
      m_cnd_r   <= m_cnd_r;
      m_valid_r <= m_valid_r;
    end else if (m_bubble) begin
      m_cnd_r   <= 1'b0;
      m_valid_r <= 1'b0;
    end else begin
      m_cnd_r   <= e_cnd_s;
      m_valid_r <= e_valid;
    end
  end

  assign cc      = cc_r;
  assign e_cnd   = e_cnd_s;
  assign m_cnd   = m_cnd_r;
  assign m_valid = m_valid_r;

endmodule

// File: tb/tb_cc_cond_unit.sv
// Self-checking bench for cc_cond_unit: per-cycle comparison against a behavioural
// model plus directed literal expectations.
module tb_cc_cond_unit;

  logic       clk;
  logic       rst;
  logic       e_valid;
  logic [3:0] e_icode;
  logic [3:0] e_ifun;
  logic [2:0] alu_cf;
  logic       cc_hold;
  logic       m_stall;
  logic       m_bubble;
  logic [2:0] cc;
  logic       e_cnd;
  logic       m_cnd;
  logic       m_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [3:0] IC_CMOV = 4'h2;
  localparam logic [3:0] IC_OPQ  = 4'h6;
  localparam logic [3:0] IC_JXX  = 4'h7;
  localparam logic [3:0] IC_NOP  = 4'h1;

  cc_cond_unit dut (
    .clk(clk), .rst(rst), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
    .alu_cf(alu_cf), .cc_hold(cc_hold), .m_stall(m_stall), .m_bubble(m_bubble),
    .cc(cc), .e_cnd(e_cnd), .m_cnd(m_cnd), .m_valid(m_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural meaning of each branch condition.
  function automatic bit model_cond(input bit v, input logic [3:0] ic,
                                    input logic [3:0] fn, input logic [2:0] f);
    bit zf, sf, of, lt;
    zf = f[0];
    sf = f[1];
    of = f[2];
    lt = (sf != of);
    if (!v || !(ic == IC_JXX || ic == IC_CMOV)) return 1'b0;
    case (fn)
      4'd0:    return 1'b1;
      4'd1:    return lt || zf;
      4'd2:    return lt;
      4'd3:    return zf;
      4'd4:    return !zf;
      4'd5:    return !lt;
      4'd6:    return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  logic [2:0] mdl_cc;
  bit         mdl_m_cnd;
  bit         mdl_m_valid;
  bit         mdl_live = 1'b0;

  // Model state advances on the active edge.
  always @(posedge clk) begin
    if (rst) begin
      mdl_cc      <= 3'b001;
      mdl_m_cnd   <= 1'b0;
      mdl_m_valid <= 1'b0;
      mdl_live    <= 1'b1;
    end else begin
      if (e_valid && e_icode == IC_OPQ && !cc_hold) mdl_cc <= alu_cf;
      if (m_stall) begin
        mdl_m_cnd   <= mdl_m_cnd;
        mdl_m_valid <= mdl_m_valid;
      end else if (m_bubble) begin
        mdl_m_cnd   <= 1'b0;
        mdl_m_valid <= 1'b0;
      end else begin
        mdl_m_cnd   <= model_cond(e_valid, e_icode, e_ifun, mdl_cc);
        mdl_m_valid <= e_valid;
      end
    end
  end

  // Compare process: mid-cycle, inputs and outputs stable.
  always @(negedge clk) begin
    if (mdl_live) begin
      check("model_cc", cc, mdl_cc);
      check("model_e_cnd", {2'b00, e_cnd}, {2'b00, model_cond(e_valid, e_icode, e_ifun, mdl_cc)});
      check("model_m_cnd", {2'b00, m_cnd}, {2'b00, mdl_m_cnd});
      check("model_m_valid", {2'b00, m_valid}, {2'b00, mdl_m_valid});
    end
  end

  // One cycle of stimulus, applied shortly after the active edge.
  task automatic step(input bit r, input bit v, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [2:0] cf, input bit hold, input bit stall, input bit bub);
    @(posedge clk);
    #2;
    rst = r; e_valid = v; e_icode = ic; e_ifun = fn;
    alu_cf = cf; cc_hold = hold; m_stall = stall; m_bubble = bub;
    #2;
  endtask

  task automatic lit(input string name, input logic [2:0] act, input logic [2:0] exp);
    check(name, act, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; e_valid = 1'b1; e_icode = IC_OPQ; e_ifun = 4'h0;
    alu_cf = 3'b110; cc_hold = 1'b0; m_stall = 1'b0; m_bubble = 1'b0;

    step(1, 1, IC_OPQ, 4'h0, 3'b110, 0, 0, 0);
    step(0, 1, IC_JXX, 4'h3, 3'b000, 0, 0, 0);
    lit("rst_cc", cc, 3'b001);
    lit("rst_m_cnd", {2'b00, m_cnd}, 3'b000);
    lit("rst_m_valid", {2'b00, m_valid}, 3'b000);
    lit("rst_je", {2'b00, e_cnd}, 3'b001);

    step(0, 1, IC_OPQ, 4'h0, 3'b010, 0, 0, 0);
    lit("opq_e_cnd", {2'b00, e_cnd}, 3'b000);
    step(0, 1, IC_JXX, 4'h2, 3'b000, 0, 0, 0);
    lit("opq_cc", cc, 3'b010);
    lit("jl", {2'b00, e_cnd}, 3'b001);
    step(0, 1, IC_JXX, 4'h5, 3'b000, 0, 0, 0);
    lit("jge", {2'b00, e_cnd}, 3'b000);
    step(0, 1, IC_JXX, 4'h1, 3'b000, 0, 0, 0);
    lit("jle", {2'b00, e_cnd}, 3'b001);
    step(0, 1, IC_JXX, 4'h6, 3'b000, 0, 0, 0);
    lit("jg", {2'b00, e_cnd}, 3'b000);

    step(0, 1, IC_OPQ, 4'h0, 3'b100, 1, 0, 0);
    step(0, 0, IC_OPQ, 4'h0, 3'b100, 0, 0, 0);
    lit("hold_cc", cc, 3'b010);
    step(0, 1, IC_JXX, 4'h0, 3'b111, 0, 0, 0);
    lit("invalid_cc", cc, 3'b010);
    step(0, 1, IC_CMOV, 4'h0, 3'b101, 0, 0, 0);
    lit("jxx_cc", cc, 3'b010);
    lit("cmov_always", {2'b00, e_cnd}, 3'b001);

    step(0, 1, IC_OPQ, 4'h0, 3'b001, 0, 0, 0);
    step(0, 1, IC_OPQ, 4'h0, 3'b000, 0, 0, 0);
    lit("order_cc_before", cc, 3'b001);
    lit("order_opq_e_cnd", {2'b00, e_cnd}, 3'b000);
    step(0, 1, IC_JXX, 4'h3, 3'b000, 0, 0, 0);
    lit("order_cc_after", cc, 3'b000);
    lit("order_je", {2'b00, e_cnd}, 3'b000);

    step(0, 1, IC_JXX, 4'h4, 3'b000, 0, 1, 1);
    lit("pipe_e_cnd", {2'b00, e_cnd}, 3'b001);
    lit("pipe_m_cnd0", {2'b00, m_cnd}, 3'b000);
    step(0, 1, IC_JXX, 4'h4, 3'b000, 0, 0, 0);
    lit("stall_m_cnd", {2'b00, m_cnd}, 3'b000);
    step(0, 1, IC_JXX, 4'h4, 3'b000, 0, 0, 1);
    lit("normal_m_cnd", {2'b00, m_cnd}, 3'b001);
    lit("normal_m_valid", {2'b00, m_valid}, 3'b001);
    step(0, 1, IC_JXX, 4'h0, 3'b000, 0, 0, 0);
    lit("bubble_m_cnd", {2'b00, m_cnd}, 3'b000);
    lit("bubble_m_valid", {2'b00, m_valid}, 3'b000);

    step(0, 1, IC_OPQ, 4'h0, 3'b011, 0, 0, 0);
    lit("opq_no_cnd", {2'b00, e_cnd}, 3'b000);
    step(0, 0, IC_JXX, 4'h0, 3'b000, 0, 0, 0);
    lit("bubble_jmp", {2'b00, e_cnd}, 3'b000);
    step(0, 1, IC_NOP, 4'h0, 3'b000, 0, 0, 0);
    lit("nop_no_cnd", {2'b00, e_cnd}, 3'b000);

    for (int v = 0; v < 8; v++) begin
      logic [2:0] f;
      f = 3'(v);
      step(0, 1, IC_OPQ, 4'h0, f, 0, 0, 0);
      step(0, 1, IC_JXX, 4'h9, 3'b000, 0, 0, 0);
      lit("sweep_cc", cc, f);
      lit("rsv_ifun9", {2'b00, e_cnd}, 3'b000);
      step(0, 1, IC_JXX, 4'hf, 3'b000, 0, 0, 0);
      lit("rsv_ifun15", {2'b00, e_cnd}, 3'b000);
      for (int fn = 0; fn < 7; fn++) begin
        step(0, 1, IC_CMOV, 4'(fn), 3'b000, 0, (fn == 3), (fn == 5));
      end
    end

    step(0, 1, IC_OPQ, 4'h0, 3'b010, 0, 0, 0);
    step(1, 1, IC_OPQ, 4'h0, 3'b110, 0, 0, 0);
    step(0, 1, IC_JXX, 4'h1, 3'b000, 0, 0, 0);
    lit("midrst_cc", cc, 3'b001);
    lit("midrst_m_valid", {2'b00, m_valid}, 3'b000);
    lit("midrst_jle", {2'b00, e_cnd}, 3'b001);
    step(0, 0, IC_NOP, 4'h0, 3'b000, 0, 0, 0);
    step(0, 0, IC_NOP, 4'h0, 3'b000, 0, 0, 0);
    @(posedge clk);
    #6;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
